cascade_rate_divider: RTL and testbench

Two-stage programmable rate divider that replaces the fixed-constant dividers. Stage 1 divides the system clock by (period+1) and emits a one-cycle tick. Stage 2 counts stage-1 ticks and emits a one-cycle sub_tick every (sub+1) ticks. Typical use is a pixel or animation tick from the 50 MHz clock, plus a frame tick. Both divide values are runtime-loadable and parameter-defaulted.

---
 rtl/cascade_rate_divider.sv | 126 ++++++++++++
 tb/tb_cascade_rate_divider.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cascade_rate_divider.sv
`default_nettype none
// ============================================================================
// Module      : cascade_rate_divider
// Description : Two-stage programmable rate divider. Stage 1 divides the clock
//               by (period+1) and emits a one-cycle tick; stage 2 counts ticks
//               and emits a one-cycle sub_tick every (sub+1) ticks. Divide
//               values are runtime-loadable through the load strobe.
//               Optional macro RATE_DIV_ONESHOT_EN adds oneshot/done ports
//               that stop the divider after the first sub_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module cascade_rate_divider #(
    parameter int WIDTH          = 28,
    parameter int DEFAULT_PERIOD = 374999,
    parameter int SUB_WIDTH      = 5,
    parameter int DEFAULT_SUB    = 29
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 load,
    input  logic [WIDTH-1:0]     period_in,
    input  logic [SUB_WIDTH-1:0] sub_in,
`ifdef RATE_DIV_ONESHOT_EN
    input  logic                 oneshot,
    output logic                 done,
`endif
    output logic                 tick,
    output logic                 sub_tick,
    output logic [WIDTH-1:0]     count,
    output logic [SUB_WIDTH-1:0] sub_count
);

    localparam logic [WIDTH-1:0]     c_default_period = WIDTH'(DEFAULT_PERIOD);
    localparam logic [SUB_WIDTH-1:0] c_default_sub    = SUB_WIDTH'(DEFAULT_SUB);
    localparam logic [WIDTH-1:0]     c_one            = WIDTH'(1);
    localparam logic [SUB_WIDTH-1:0] c_sub_one        = SUB_WIDTH'(1);

    logic [WIDTH-1:0]     r_period;
    logic [SUB_WIDTH-1:0] r_sub;
    logic [WIDTH-1:0]     r_count;
    logic [SUB_WIDTH-1:0] r_sub_count;
    logic                 r_tick;
    logic                 r_sub_tick;

    logic w_count_zero;
    logic w_sub_zero;
    logic w_freeze;   // divider parked after a one-shot completion
    logic w_finish;   // this enabled edge completes a one-shot run

    assign w_count_zero = (r_count == '0);
    assign w_sub_zero   = (r_sub_count == '0);

`ifdef RATE_DIV_ONESHOT_EN
    logic r_done;

    assign w_freeze = r_done;
    assign w_finish = oneshot & w_count_zero & w_sub_zero;

    // Done latches on the sub_tick edge of a one-shot run; load re-arms it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_done <= 1'b0;
        end else if (load) begin
            r_done <= 1'b0;
        end else if (enable && !r_done && w_finish) begin
            r_done <= 1'b1;
        end
    end

    assign done = r_done;
`else
    assign w_freeze = 1'b0;
    assign w_finish = 1'b0;
`endif

    // Two cascaded down-counters: load restarts, enable advances, else hold.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_period    <= c_default_period;
            r_sub       <= c_default_sub;
            r_count     <= c_default_period;
            r_sub_count <= c_default_sub;
            r_tick      <= 1'b0;
            r_sub_tick  <= 1'b0;
        end else if (load) begin
            r_period    <= period_in;
            r_sub       <= sub_in;
            r_count     <= period_in;
            r_sub_count <= sub_in;
            r_tick      <= 1'b0;
            r_sub_tick  <= 1'b0;
        end else if (w_freeze) begin
            // Parked: counters already sit at zero, suppress all pulses.
            r_tick      <= 1'b0;
            r_sub_tick  <= 1'b0;
        end else if (enable) begin
            if (w_count_zero) begin
                // Stage-1 terminal count: reload and advance stage 2.
                r_count <= w_finish ? '0 : r_period;
                r_tick  <= 1'b1;
                if (w_sub_zero) begin
                    r_sub_count <= w_finish ? '0 : r_sub;
                    r_sub_tick  <= 1'b1;
                end else begin
                    r_sub_count <= r_sub_count - c_sub_one;
                    r_sub_tick  <= 1'b0;
                end
            end else begin
                r_count    <= r_count - c_one;
                r_tick     <= 1'b0;
                r_sub_tick <= 1'b0;
            end
        end else begin
            r_tick     <= 1'b0;
            r_sub_tick <= 1'b0;
        end
    end

    assign tick      = r_tick;
    assign sub_tick  = r_sub_tick;
    assign count     = r_count;
    assign sub_count = r_sub_count;

endmodule
`default_nettype wire

// File: tb/tb_cascade_rate_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_cascade_rate_divider
// Description : Self-checking bench for cascade_rate_divider. The reference
//               model tracks only the number of enabled edges since the last
//               restart and derives every output arithmetically from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cascade_rate_divider;

    localparam int WIDTH     = 28;
    localparam int SUB_WIDTH = 5;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic                 enable = 1'b0;
    logic                 load = 1'b0;
    logic [WIDTH-1:0]     period_in = '0;
    logic [SUB_WIDTH-1:0] sub_in = '0;
    logic                 tick;
    logic                 sub_tick;
    logic [WIDTH-1:0]     count;
    logic [SUB_WIDTH-1:0] sub_count;

    int errors = 0;
    int checks = 0;

    // Reference model state: divide values and enabled edges since restart.
    longint m_p;
    longint m_s;
    longint m_k;
    logic   m_tick;

    cascade_rate_divider dut (
        .clock     (clock),
        .resetn    (resetn),
        .enable    (enable),
        .load      (load),
        .period_in (period_in),
        .sub_in    (sub_in),
        .tick      (tick),
        .sub_tick  (sub_tick),
        .count     (count),
        .sub_count (sub_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p = 374999;
        m_s = 29;
        m_k = 0;
        m_tick = 1'b0;
    endtask

    // Compare all outputs against values derived from the enabled-edge count.
    task automatic check_all(input string tag);
        longint t;
        logic   e_sub_tick;
        t = m_k / (m_p + 1);
        e_sub_tick = m_tick && ((t % (m_s + 1)) == 0);
        chk({tag, ".tick"},      {63'd0, tick},     {63'd0, m_tick});
        chk({tag, ".sub_tick"},  {63'd0, sub_tick}, {63'd0, e_sub_tick});
        chk({tag, ".count"},     64'(count),        64'(m_p - (m_k % (m_p + 1))));
        chk({tag, ".sub_count"}, 64'(sub_count),    64'(m_s - (t % (m_s + 1))));
    endtask

    task automatic step(input string tag, input logic en, input logic ld,
                        input logic [WIDTH-1:0] pin, input logic [SUB_WIDTH-1:0] sin);
        enable    = en;
        load      = ld;
        period_in = pin;
        sub_in    = sin;
        @(posedge clock);
        #1;
        if (ld) begin
            m_p = longint'(pin);
            m_s = longint'(sin);
            m_k = 0;
            m_tick = 1'b0;
        end else if (en) begin
            m_k++;
            m_tick = ((m_k % (m_p + 1)) == 0);
        end else begin
            m_tick = 1'b0;
        end
        load = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        // Reset state
        #12;
        check_all("reset");
        @(posedge clock);
        #3 resetn = 1'b1;

        // Free-run a few edges from the default divide values
        for (int i = 0; i < 4; i++) step("default", 1'b1, 1'b0, '0, '0);

        // Load period 3 / sub 2: ticks on edges 4,8,12..., sub_tick on 12, 24
        step("load3_2", 1'b1, 1'b1, 28'd3, 5'd2);
        for (int i = 0; i < 26; i++) step("p3s2", 1'b1, 1'b0, '0, '0);

        // Period 0 / sub 0: pulses every cycle, counters pinned at zero
        step("load0_0", 1'b1, 1'b1, 28'd0, 5'd0);
        for (int i = 0; i < 6; i++) step("p0s0", 1'b1, 1'b0, '0, '0);

        // Period 5: pause for 7 cycles at count==2, then resume
        step("load5_1", 1'b1, 1'b1, 28'd5, 5'd1);
        for (int i = 0; i < 3; i++) step("p5run", 1'b1, 1'b0, '0, '0);
        chk("p5.count_at_pause", 64'(count), 64'd2);
        for (int i = 0; i < 7; i++) step("p5hold", 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step("p5resume", 1'b1, 1'b0, '0, '0);

        // Load coinciding with the terminal-count edge suppresses the tick
        step("load3_0", 1'b1, 1'b1, 28'd3, 5'd0);
        for (int i = 0; i < 3; i++) step("p3run", 1'b1, 1'b0, '0, '0);
        chk("p3.count_zero", 64'(count), 64'd0);
        step("load_on_zero", 1'b1, 1'b1, 28'd6, 5'd1);
        chk("load_on_zero.no_tick", {63'd0, tick}, 64'd0);
        for (int i = 0; i < 8; i++) step("p6run", 1'b1, 1'b0, '0, '0);

        // Randomized loads and enable patterns
        for (int i = 0; i < 400; i++) begin
            logic ld;
            logic en;
            ld = ($urandom_range(0, 19) == 0);
            en = ($urandom_range(0, 3) != 0);
            step("random", en, ld, WIDTH'($urandom_range(0, 7)), SUB_WIDTH'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-count, arriving while tick is high
        step("load3_pre_rst", 1'b1, 1'b1, 28'd3, 5'd2);
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 1'b0, '0, '0);
        chk("pre_rst.tick_high", {63'd0, tick}, 64'd1);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clock);
        #1;
        check_all("rst_held");
        #2 resetn = 1'b1;
        for (int i = 0; i < 5; i++) step("post_rst", 1'b1, 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
